// File: rtl/sata_cont_inserter.sv
// -----------------------------------------------------------------------------
// sata_cont_inserter
//
// Transmit-side SATA link-layer CONT inserter. It watches the outgoing dword
// stream for runs of one repeated primitive. Such a run is sent as P, P, CONT,
// followed by scrambled junk data dwords until the primitive changes. ALIGN
// primitives pass through without breaking a continuation. CONT inputs and
// data dwords pass through unchanged and end any run that is being tracked.
//
// Ports
//   clk        : dword clock, one dword per cycle, no stalls
//   reset      : asynchronous, active-high; clears all state and outputs
//   i_cont_en  : 1 = CONT insertion enabled, 0 = registered bypass
//   i_data     : transmit dword
//   i_datak    : 1 = i_data is a primitive
//   o_data     : output dword (one cycle after the input)
//   o_datak    : primitive flag of o_data
//
// Parameters
//   SEED       : reset value of the 16-bit junk-generator LFSR
// -----------------------------------------------------------------------------
module sata_cont_inserter #(
  parameter logic [15:0] SEED = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_cont_en,
  input  logic [31:0] i_data,
  input  logic        i_datak,
  output logic [31:0] o_data,
  output logic        o_datak
);

  // Primitive codes shared with the rest of the link layer.
  localparam logic [31:0] CONT_PRIM  = 32'h9999AA7C;
  localparam logic [31:0] ALIGN_PRIM = 32'h7B4A4ABC;

  // Feedback taps of x^16+x^15+x^13+x^4+1, Galois form. The x^16 term is
  // the bit shifted out of the top of the register.
  localparam logic [15:0] LFSR_TAPS = 16'hA011;

  typedef enum logic [1:0] {
    NONE  = 2'd0,  // nothing tracked
    REP1  = 2'd1,  // tracked primitive sent once
    REP2  = 2'd2,  // tracked primitive sent twice
    CONTD = 2'd3   // CONT sent, junk in progress
  } state_e;

  state_e      state_q,     state_d;
  logic [31:0] last_prim_q, last_prim_d;
  logic [15:0] lfsr_q,      lfsr_d;
  logic [31:0] data_q,      data_d;
  logic        datak_q,     datak_d;

  // ---------------------------------------------------------------------------
  // Junk generator: 32 serial steps of the SATA scrambler LFSR, unrolled into
  // one combinational step. Output bit i is the register MSB before step i.
  // This gives the same dword sequence as the SATA data scrambler.
  // Returns {next_lfsr, junk_word}.
  // ---------------------------------------------------------------------------
  function automatic logic [47:0] scramble_step(input logic [15:0] ctx);
    logic [15:0] c;
    logic [31:0] w;
    // NOTE: inside a function, blocking '=' is right because each loop pass
    // must see the previous pass's value; registers below use '<=' instead.
    c = ctx;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      w[i] = c[15];
      c    = c[15] ? ((c << 1) ^ LFSR_TAPS) : (c << 1);
    end
    return {c, w};
  endfunction

  logic [15:0] lfsr_adv;
  logic [31:0] junk_word;

  assign {lfsr_adv, junk_word} = scramble_step(lfsr_q);

  // ---------------------------------------------------------------------------
  // Input classification
  // ---------------------------------------------------------------------------
  logic is_align;
  logic eligible;
  logic repeat_hit;

  assign is_align = i_datak && (i_data == ALIGN_PRIM);
  assign eligible = i_datak && (i_data != ALIGN_PRIM) && (i_data != CONT_PRIM);

  // A match only counts while a run is being tracked. After a data dword,
  // a CONT or bypass, an equal primitive therefore restarts at REP1.
  assign repeat_hit = (state_q != NONE) && (i_data == last_prim_q);

  // ---------------------------------------------------------------------------
  // State register (also holds the registered outputs and the LFSR)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= NONE;
      last_prim_q <= 32'h0;
      lfsr_q      <= SEED;
      data_q      <= 32'h0;
      datak_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_prim_q <= last_prim_d;
      lfsr_q      <= lfsr_d;
      data_q      <= data_d;
      datak_q     <= datak_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    last_prim_d = last_prim_q;

    if (!i_cont_en) begin
      state_d = NONE;
    end else if (eligible) begin
      if (!repeat_hit) begin
        state_d     = REP1;
        last_prim_d = i_data;
      end else begin
        unique case (state_q)
          REP1:    state_d = REP2;
          REP2:    state_d = CONTD;
          CONTD:   state_d = CONTD;
          default: state_d = REP1;
        endcase
      end
    end else if (!is_align) begin
      // Data dword or an illegal CONT from upstream ends the run.
      state_d = NONE;
    end
    // An ALIGN keeps state and last_prim, so the continuation survives it.
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  logic emit_cont;
  logic emit_junk;

  assign emit_cont = i_cont_en && eligible && repeat_hit && (state_q == REP2);
  assign emit_junk = i_cont_en && eligible && repeat_hit && (state_q == CONTD);

  always_comb begin
    data_d  = i_data;
    datak_d = i_datak;
    lfsr_d  = lfsr_q;

    if (emit_cont) begin
      data_d  = CONT_PRIM;
      datak_d = 1'b1;
    end else if (emit_junk) begin
      // Junk is always sent as data, so the PHY never sees it as a primitive.
      data_d  = junk_word;
      datak_d = 1'b0;
      lfsr_d  = lfsr_adv;
    end
  end

  assign o_data  = data_q;
  assign o_datak = datak_q;

endmodule
